fetch_unit: RTL and testbench
=============================

# fetch_unit

Parametrised instruction-fetch stage for the RV32I core. It replaces free-running counter-driven instruction ROM reads with a byte-addressed program counter, a valid/ready output handshake towards the decoder, and PC redirection for branches and jumps. It detects misaligned and out-of-range fetches and reports them as faults. Instruction storage is an internal `bram_sdp` instance preloaded from a memory file.

## Interface
Parameters:
- `XLEN`, 32: PC and instruction width.
- `DEPTH`, 128: instruction memory depth in words. Must be a power of two and at least 2.
- `RESET_PC`, 0: byte address fetched first after reset. Must be 4-byte aligned.
- `INIT`, "instructions.mem": memory init file passed to `bram_sdp`.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset_n` in 1: synchronous, active-low reset.
- `redirect_valid` in 1: load a new PC this cycle.
- `redirect_pc` in XLEN: target byte address.
- `instr_ready` in 1: downstream accepts `instr`.
- `instr_valid` out 1: `instr`, `instr_pc` and `instr_fault` are valid.
- `instr` out XLEN: fetched instruction word.
- `instr_pc` out XLEN: byte address of `instr`.
- `instr_fault` out 1: this entry is a fault, not an instruction.
- `fetch_count` out 32: number of completed handshakes. Wraps at 2^32.

## Operation
- `AW = $clog2(DEPTH)`. Word index = `pc[AW+1:2]`.
- **Issuable address:** `pc[1:0] == 0` and `pc < DEPTH*4`. Any other address is a fault.
- **Stages:**
  - F0 holds `pc`.
  - F1 holds `f1_valid`, `f1_pc`, `f1_fault`, plus the BRAM output.
- **Outputs:**
  - `instr_valid = f1_valid`; `instr_pc = f1_pc`; `instr_fault = f1_fault`.
  - `instr` = BRAM `data_out`, or `NOP` (32'h0000_0013) when `f1_fault`.
- **Handshake:**
  - Transfer occurs when `instr_valid && instr_ready`.
  - `advance = !f1_valid || instr_ready`.
- **Read enable:** BRAM `read_enable` = `advance && state==RUN && issuable(pc)`. `bram_sdp` holds `data_out` while `read_enable` is low, so a stalled output stays stable with no skid buffer.
- **State machine (`RUN`, `HALT`):**
  - In RUN with `advance`:
    - Issuable pc: `f1_valid<=1`, `f1_fault<=0`, `f1_pc<=pc`, `pc<=pc+4`.
    - Non-issuable pc: `f1_valid<=1`, `f1_fault<=1`, `f1_pc<=pc`, state goes to HALT, `pc` unchanged.
  - In RUN without `advance`: hold everything.
  - In HALT: issue nothing. When the fault entry transfers, `f1_valid<=0`. Stay in HALT until a redirect.
- **Redirect (highest priority after reset):**
  - `pc<=redirect_pc`, `f1_valid<=0`, state goes to RUN.
  - Any output transfer in the same cycle still counts and is not replayed.
  - No read is issued in the redirect cycle.
- **PC arithmetic:** `pc+4` is modulo 2^XLEN. Running off the end of memory (for example, pc = DEPTH*4) produces a fault on the next issue and does not wrap to 0.
- **`fetch_count`:** increments on every transfer, including fault entries.

## Timing
- **Reset values** (while `reset_n` is low at a clock edge):
  - `pc=RESET_PC`, state RUN, `f1_valid=0`, `f1_fault=0`, `fetch_count=0`.
  - Hence `instr_valid=0`, `instr_fault=0`, `instr_pc=0` (F1 PC register cleared).
- **After reset:** the first cycle with `reset_n` high issues `RESET_PC`. `instr_valid` rises on the next edge, giving 1-cycle latency.
- **Throughput:** one instruction per cycle while `instr_ready` is held high.
- **Redirect latency:** redirect asserted in cycle N, read of the target in N+1, `instr_valid` for the target in N+2. `instr_valid` is low in N+1.
- **Stall:** with `instr_ready` low, all outputs hold bit-exact for any number of cycles.
- **Reset mid-stream:** in-flight F1 content is dropped, with no output in the cycle after reset.
- **Fault during stall:** the fault entry stays presented until accepted or a redirect arrives.

## Structure
- Package `fetch_pkg`:
  - `typedef enum logic {RUN, HALT} fetch_state_t`
  - `localparam logic [31:0] NOP = 32'h0000_0013`
- Sub-module: the existing `bram_sdp` (`WIDTH=XLEN`, `DEPTH`, `INIT`), with the write port tied off.
- Under `SIMULATION`, `$display` PC, instr and fault on each transfer.

## Test plan
- **Reset/stream:** reset, then `instr_ready=1` with memory words 0..3 = A,B,C,D. Required: `instr_pc` reads 0, 4, 8, 12 on consecutive cycles with instr A..D; `fetch_count=4`; first `instr_valid` one cycle after reset release.
- **Stall:** drop `instr_ready` for 5 cycles while `instr_pc=8`. Required: outputs hold C/8 unchanged; after release D/12 follows the next cycle; no duplicates or losses.
- **Redirect:** assert `redirect_valid` with `redirect_pc=0x40` while `instr_pc=4` is being accepted. Required: entry 4 counted once; one bubble cycle; then `instr_pc=0x40` with mem[16].
- **Misaligned:** redirect to 0x42. Required: one entry with `instr_fault=1`, `instr_pc=0x42`, `instr=0x00000013`; then `instr_valid=0` until redirect to 0 resumes normal fetch.
- **End of memory:** with `DEPTH=8`, stream from 0. Required: 8 valid words (pc 0..28), then a fault at pc 32, then silence.
- **Reset mid-operation:** pull `reset_n` low for 1 cycle during a stall. Required: `instr_valid=0` and `fetch_count=0` next cycle, then a restart from `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// ============================================================================
// fetch_pkg : shared state type and constants for the instruction-fetch stage
// Revision  : 1.0
// ============================================================================
package fetch_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  // addi x0, x0, 0 -- presented in place of data on a fault entry
  localparam logic [31:0] NOP = 32'h0000_0013;

endpackage
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// fetch_unit_if : redirect input and valid/ready instruction output bundle
// Revision      : 1.0
// ============================================================================
interface fetch_unit_if #(
  parameter int XLEN = 32
);

  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            instr_ready;
  logic            instr_valid;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;
  logic            instr_fault;
  logic [31:0]     fetch_count;

  // master = fetch stage, slave = decoder / branch unit side
  modport master (
    input  redirect_valid, redirect_pc, instr_ready,
    output instr_valid, instr, instr_pc, instr_fault, fetch_count
  );

  modport slave (
    output redirect_valid, redirect_pc, instr_ready,
    input  instr_valid, instr, instr_pc, instr_fault, fetch_count
  );

endinterface
`default_nettype wire

// File: rtl/bram_sdp.sv
`default_nettype none
// ============================================================================
// bram_sdp : simple dual-port block RAM, registered read that holds when idle
// Revision : 1.0
// ============================================================================
module bram_sdp #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 128,
  parameter     INIT  = ""
) (
  input  wire logic                     clk,
  input  wire logic                     write_enable,
  input  wire logic [$clog2(DEPTH)-1:0] write_addr,
  input  wire logic [WIDTH-1:0]         write_data,
  input  wire logic                     read_enable,
  input  wire logic [$clog2(DEPTH)-1:0] read_addr,
  output      logic [WIDTH-1:0]         data_out
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] data_out_q;

  always_ff @(posedge clk) begin
    if (write_enable) begin
      mem[write_addr] <= write_data;
    end
    if (read_enable) begin
      data_out_q <= mem[read_addr];
    end
  end

  assign data_out = data_out_q;

endmodule
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// fetch_unit : two-stage RV32I instruction fetch with redirect and fault entry
// Revision   : 1.0
// ============================================================================
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 128,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter                  INIT     = "instructions.mem"
) (
  input wire logic     clock,
  input wire logic     reset_n,
  fetch_unit_if.master bus
);

  localparam int AW = $clog2(DEPTH);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] f1_pc_q, f1_pc_d;
  logic            f1_valid_q, f1_valid_d;
  logic            f1_fault_q, f1_fault_d;
  logic [31:0]     fetch_count_q, fetch_count_d;

  logic            transfer;
  logic            advance;
  logic            issuable;
  logic            read_enable;
  logic [XLEN-1:0] bram_data;

  assign transfer = f1_valid_q && bus.instr_ready;
  assign advance  = !f1_valid_q || bus.instr_ready;
  // Anything at or beyond DEPTH*4 faults instead of wrapping into the array.
  assign issuable = (pc_q[1:0] == 2'b00) && (pc_q[XLEN-1:AW+2] == '0);
  assign read_enable = advance && (state_q == RUN) && issuable && !bus.redirect_valid;

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    f1_pc_d       = f1_pc_q;
    f1_valid_d    = f1_valid_q;
    f1_fault_d    = f1_fault_q;
    fetch_count_d = fetch_count_q;

    if (transfer) begin
      fetch_count_d = fetch_count_q + 32'd1;
    end

    if (bus.redirect_valid) begin
      pc_d       = bus.redirect_pc;
      f1_valid_d = 1'b0;
      state_d    = RUN;
    end else begin
      case (state_q)
        RUN: begin
          if (advance) begin
            f1_valid_d = 1'b1;
            f1_pc_d    = pc_q;
            if (issuable) begin
              f1_fault_d = 1'b0;
              pc_d       = pc_q + XLEN'(4);
            end else begin
              f1_fault_d = 1'b1;
              state_d    = HALT;
            end
          end
        end
        HALT: begin
          if (transfer) begin
            f1_valid_d = 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      f1_pc_q       <= '0;
      f1_valid_q    <= 1'b0;
      f1_fault_q    <= 1'b0;
      fetch_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      f1_pc_q       <= f1_pc_d;
      f1_valid_q    <= f1_valid_d;
      f1_fault_q    <= f1_fault_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  // data_out holds while read_enable is low, so a stalled entry stays stable.
  bram_sdp #(
    .WIDTH (XLEN),
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) u_bram (
    .clk          (clock),
    .write_enable (1'b0),
    .write_addr   ('0),
    .write_data   ('0),
    .read_enable  (read_enable),
    .read_addr    (pc_q[AW+1:2]),
    .data_out     (bram_data)
  );

  assign bus.instr_valid = f1_valid_q;
  assign bus.instr_pc    = f1_pc_q;
  assign bus.instr_fault = f1_fault_q;
  assign bus.instr       = f1_fault_q ? XLEN'(NOP) : bram_data;
  assign bus.fetch_count = fetch_count_q;

`ifdef SIMULATION
  always_ff @(posedge clock) begin
    if (reset_n && transfer) begin
      $display("fetch: pc=%h instr=%h fault=%0b", f1_pc_q, bus.instr, f1_fault_q);
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_fetch_unit : directed vector bench for fetch_unit (DEPTH 128 and DEPTH 8)
// Revision      : 1.0
// ============================================================================
module tb_fetch_unit;
  import fetch_pkg::*;

  logic clock = 1'b0;
  logic rst_n;
  logic rst8_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  fetch_unit_if #(.XLEN(32)) bus  ();
  fetch_unit_if #(.XLEN(32)) bus8 ();

  fetch_unit #(
    .XLEN(32), .DEPTH(128), .RESET_PC(32'h0), .INIT("instructions.mem")
  ) dut (
    .clock   (clock),
    .reset_n (rst_n),
    .bus     (bus)
  );

  fetch_unit #(
    .XLEN(32), .DEPTH(8), .RESET_PC(32'h0), .INIT("instructions.mem")
  ) dut8 (
    .clock   (clock),
    .reset_n (rst8_n),
    .bus     (bus8)
  );

  function automatic logic [31:0] w128(input int i);
    return 32'hC0DE_0000 + 32'(i);
  endfunction

  function automatic logic [31:0] w8(input int i);
    return 32'h8800_0000 + 32'(i);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [31:0] rpc;
    logic        exp_v;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    logic        exp_fault;
    logic [31:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(input logic rdy, input logic rv, input logic [31:0] rpc,
                              input logic v, input logic [31:0] pc, input logic [31:0] ins,
                              input logic f, input logic [31:0] cnt);
    vec_t t;
    t.rdy = rdy; t.rv = rv; t.rpc = rpc;
    t.exp_v = v; t.exp_pc = pc; t.exp_instr = ins; t.exp_fault = f; t.exp_cnt = cnt;
    return t;
  endfunction

  vec_t vecs [24];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // Each row: expected outputs visible now, inputs applied for the next edge
    vecs[0]  = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd0);
    vecs[1]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  w128(0),   1'b0, 32'd0);
    vecs[2]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h4,  w128(1),   1'b0, 32'd1);
    vecs[3]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  w128(2),   1'b0, 32'd2);
    vecs[4]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  w128(2),   1'b0, 32'd2);
    vecs[5]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  w128(2),   1'b0, 32'd2);
    vecs[6]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  w128(2),   1'b0, 32'd2);
    vecs[7]  = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h8,  w128(2),   1'b0, 32'd2);
    vecs[8]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h8,  w128(2),   1'b0, 32'd2);
    vecs[9]  = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'hC, w128(3),    1'b0, 32'd3);
    vecs[10] = mk(1'b0, 1'b1, 32'h4,  1'b1, 32'h10, w128(4),   1'b0, 32'd4);
    vecs[11] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd4);
    vecs[12] = mk(1'b1, 1'b1, 32'h40, 1'b1, 32'h4,  w128(1),   1'b0, 32'd4);
    vecs[13] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd5);
    vecs[14] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h40, w128(16),  1'b0, 32'd5);
    vecs[15] = mk(1'b0, 1'b1, 32'h42, 1'b1, 32'h44, w128(17),  1'b0, 32'd6);
    vecs[16] = mk(1'b0, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd6);
    vecs[17] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h42, 32'h0000_0013, 1'b1, 32'd6);
    vecs[18] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h42, 32'h0000_0013, 1'b1, 32'd6);
    vecs[19] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd7);
    vecs[20] = mk(1'b1, 1'b1, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd7);
    vecs[21] = mk(1'b1, 1'b0, 32'h0,  1'b0, 32'h0,  32'h0,     1'b0, 32'd7);
    vecs[22] = mk(1'b1, 1'b0, 32'h0,  1'b1, 32'h0,  w128(0),   1'b0, 32'd7);
    vecs[23] = mk(1'b0, 1'b0, 32'h0,  1'b1, 32'h4,  w128(1),   1'b0, 32'd8);

    rst_n  = 1'b0;
    rst8_n = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_pc     = 32'h0;
    bus.instr_ready     = 1'b0;
    bus8.redirect_valid = 1'b0;
    bus8.redirect_pc    = 32'h0;
    bus8.instr_ready    = 1'b0;
    for (int i = 0; i < 128; i++) dut.u_bram.mem[i] <= w128(i);
    for (int i = 0; i < 8; i++) dut8.u_bram.mem[i] <= w8(i);

    repeat (3) @(negedge clock);
    check("reset valid", 32'(bus.instr_valid), 32'd0);
    check("reset fault", 32'(bus.instr_fault), 32'd0);
    check("reset pc",    bus.instr_pc,         32'h0);
    check("reset count", bus.fetch_count,      32'd0);
    rst_n = 1'b1;

    for (int r = 0; r < 24; r++) begin
      if (r != 0) @(negedge clock);
      check($sformatf("row%0d valid", r), 32'(bus.instr_valid), 32'(vecs[r].exp_v));
      check($sformatf("row%0d count", r), bus.fetch_count, vecs[r].exp_cnt);
      if (vecs[r].exp_v) begin
        check($sformatf("row%0d pc", r),    bus.instr_pc, vecs[r].exp_pc);
        check($sformatf("row%0d instr", r), bus.instr, vecs[r].exp_instr);
        check($sformatf("row%0d fault", r), 32'(bus.instr_fault), 32'(vecs[r].exp_fault));
      end
      bus.instr_ready    = vecs[r].rdy;
      bus.redirect_valid = vecs[r].rv;
      bus.redirect_pc    = vecs[r].rpc;
    end

    // Reset for one cycle in the middle of a stall
    @(negedge clock);
    check("stall before reset pc", bus.instr_pc, 32'h4);
    rst_n = 1'b0;
    @(negedge clock);
    check("midreset valid", 32'(bus.instr_valid), 32'd0);
    check("midreset count", bus.fetch_count,      32'd0);
    check("midreset pc",    bus.instr_pc,         32'h0);
    check("midreset fault", 32'(bus.instr_fault), 32'd0);
    rst_n = 1'b1;
    bus.instr_ready = 1'b1;
    @(negedge clock);
    check("restart valid", 32'(bus.instr_valid), 32'd1);
    check("restart pc",    bus.instr_pc,         32'h0);
    check("restart instr", bus.instr,            w128(0));
    check("restart count", bus.fetch_count,      32'd0);

    // DEPTH=8 instance streams off the end of memory
    rst8_n = 1'b1;
    bus8.instr_ready = 1'b1;
    for (int k = 0; k < 13; k++) begin
      if (k != 0) @(negedge clock);
      if (k == 0 || k >= 10) begin
        check($sformatf("eom k%0d valid", k), 32'(bus8.instr_valid), 32'd0);
        check($sformatf("eom k%0d count", k), bus8.fetch_count, (k == 0) ? 32'd0 : 32'd9);
      end else if (k == 9) begin
        check("eom fault valid", 32'(bus8.instr_valid), 32'd1);
        check("eom fault flag",  32'(bus8.instr_fault), 32'd1);
        check("eom fault pc",    bus8.instr_pc,         32'h20);
        check("eom fault instr", bus8.instr,            32'h0000_0013);
        check("eom fault count", bus8.fetch_count,      32'd8);
      end else begin
        check($sformatf("eom k%0d valid", k), 32'(bus8.instr_valid), 32'd1);
        check($sformatf("eom k%0d fault", k), 32'(bus8.instr_fault), 32'd0);
        check($sformatf("eom k%0d pc", k),    bus8.instr_pc,   32'((k - 1) * 4));
        check($sformatf("eom k%0d instr", k), bus8.instr,      w8(k - 1));
        check($sformatf("eom k%0d count", k), bus8.fetch_count, 32'(k - 1));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
